// File: rtl/hazard_pkg.sv
// hazard_pkg: shared defaults and width helpers for the hazard scoreboard
package hazard_pkg;

    localparam int MAX_LAT_DEF = 3;
    localparam int STAT_W      = 16;

    function automatic int lw_of(input int max_lat);
        return $clog2(max_lat + 1);
    endfunction

    function automatic int aw_of(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage operand/destination bundle and hazard response
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int NSRC    = 2,
    parameter int MAX_LAT = MAX_LAT_DEF
);

    localparam int AW = aw_of(NREGS);
    localparam int LW = lw_of(MAX_LAT);

    logic [NSRC-1:0]    src_valid;
    logic [NSRC*AW-1:0] src_reg;
    logic               dst_valid;
    logic [AW-1:0]      dst_reg;
    logic [LW-1:0]      dst_lat;
    logic               issue;
    logic               stall;
    logic [NSRC-1:0]    fwd_sel;

    modport master (
        output src_valid, src_reg, dst_valid, dst_reg, dst_lat, issue,
        input  stall, fwd_sel
    );

    modport slave (
        input  src_valid, src_reg, dst_valid, dst_reg, dst_lat, issue,
        output stall, fwd_sel
    );

endinterface

// File: rtl/hazard_scoreboard_reg_countdown.sv
// reg_countdown: cycles-until-writeback counter for one architectural register
module reg_countdown
    import hazard_pkg::*;
#(
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int LW      = lw_of(MAX_LAT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [LW-1:0] lat,
    output logic [LW-1:0] cnt,
    output logic          busy
);

    localparam logic [LW-1:0] CAP = LW'(MAX_LAT);

    logic [LW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // A new producer reload wins over the countdown; busy tracks the next count
    always_comb begin
        cnt_d  = load ? ((lat > CAP) ? CAP : lat)
                      : ((cnt_q != '0) ? cnt_q - LW'(1) : cnt_q);
        busy_d = cnt_d != '0;
    end

    // Count and busy flag, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW/WAW interlock with optional result-bus bypass.
// Define HAZARD_FWD_EN to let operands one cycle from writeback use the bypass
// instead of stalling; otherwise decode waits until the count reaches zero.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int NSRC    = 2,
    parameter int MAX_LAT = MAX_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_scoreboard_if.slave    bus,
    input  logic                  clr_stats,
    output logic [NREGS-1:0]      pending,
    output logic [STAT_W-1:0]     stall_cycles
);

    localparam int AW = aw_of(NREGS);
    localparam int LW = lw_of(MAX_LAT);
`ifdef HAZARD_FWD_EN
    localparam int THR = 1;
`else
    localparam int THR = 0;
`endif

    logic [LW-1:0]     cnt [NREGS];
    logic              raw, waw, stall, acc;
    logic [AW-1:0]     s;
    logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
`ifdef HAZARD_FWD_EN
    logic [NSRC-1:0]   fwd;
`endif

    assign cnt[0]     = '0;
    assign pending[0] = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : g_reg
        reg_countdown #(.MAX_LAT(MAX_LAT), .LW(LW)) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .load (acc && bus.dst_reg == AW'(g)),
            .lat  (bus.dst_lat),
            .cnt  (cnt[g]),
            .busy (pending[g])
        );
    end

    // Per-operand RAW check against the pre-issue counts, plus bypass select
    always_comb begin
        raw = 1'b0;
        s   = '0;
`ifdef HAZARD_FWD_EN
        fwd = '0;
`endif
        for (int i = 0; i < NSRC; i++) begin
            s   = bus.src_reg[i*AW +: AW];
            raw = raw | (bus.src_valid[i] && s != '0 && cnt[s] > LW'(THR));
`ifdef HAZARD_FWD_EN
            fwd[i] = bus.src_valid[i] && s != '0 && cnt[s] == LW'(1);
`endif
        end
    end

    // WAW check, overall stall, and whether this cycle's issue is accepted
    always_comb begin
        waw   = bus.dst_valid && bus.dst_reg != '0 && cnt[bus.dst_reg] > bus.dst_lat;
        stall = raw | waw;
        acc   = bus.issue && !stall && bus.dst_valid && bus.dst_reg != '0 && bus.dst_lat != '0;
    end

    // Saturating stall counter; clear takes priority over counting
    always_comb begin
        stall_cycles_d = clr_stats ? '0
                       : (stall && stall_cycles_q != '1) ? stall_cycles_q + STAT_W'(1)
                       : stall_cycles_q;
    end

    // Stall statistics register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles_q <= '0;
        else        stall_cycles_q <= stall_cycles_d;
    end

    assign bus.stall    = stall;
    assign stall_cycles = stall_cycles_q;
`ifdef HAZARD_FWD_EN
    assign bus.fwd_sel  = fwd;
`else
    assign bus.fwd_sel  = '0;
`endif

endmodule
